somador_acumulador_5bits: RTL and testbench
===========================================

Name: somador_acumulador_5bits

Overview:
- Downstream consumer of the 5-bit down-counter output.
- Accepts a fixed number of 5-bit samples (N_SAMPLES) over a valid/ready handshake and adds them into a SUM_W-bit accumulator.
- Presents the finished sum on a second valid/ready handshake.
- Gives the counter/adder datapath a sequential "sum of counted values" stage.

Parameters:
- IN_W, 5, sample width; must match the counter output width.
- SUM_W, 8, accumulator and result width; SUM_W >= IN_W.
- N_SAMPLES, 4, samples summed per run; legal range 1..31.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- clear  input  1  reset; asynchronous, active-low.
- start  input  1  begin a new accumulation run; sampled only in IDLE, or in HOLD during the result handshake.
- in_data  input  IN_W  sample, zero-extended before addition.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- sum  output  SUM_W  accumulated result.
- sum_valid  output  1  sum is valid.
- sum_ready  input  1  consumer takes sum this cycle.
- busy  output  1  high in ACCUM and HOLD.
- overflow  output  1  sticky carry-out flag for the current or last run.

Behaviour:
- Reset (clear=0, asynchronous, takes effect immediately including mid-run):
  - state=IDLE; acc=0, sum=0, sample count=0.
  - sum_valid=0, in_ready=0, busy=0, overflow=0.
- States: IDLE, ACCUM, HOLD. in_ready, busy and sum_valid are decoded from the registered state only; no combinational path from inputs.
- IDLE:
  - in_ready=0, sum_valid=0, busy=0.
  - start=1 at a rising edge -> ACCUM; acc<=0, cnt<=0, overflow<=0.
  - sum keeps the previous result.
- ACCUM:
  - in_ready=1, busy=1.
  - A sample is accepted only when in_valid and in_ready are both 1 at a rising edge: acc <= acc + zero_extend(in_data), modulo 2^SUM_W; overflow <= 1 on carry-out; cnt <= cnt+1.
  - Cycles with in_valid=0 change nothing.
  - When the accepted sample is number N_SAMPLES (cnt == N_SAMPLES-1): sum <= acc + in_data (same arithmetic rule); state -> HOLD.
  - Latency: sum_valid=1 in the cycle after the last accepted sample.
  - start is ignored in ACCUM.
- HOLD:
  - sum_valid=1, in_ready=0, busy=1; sum and overflow held stable.
  - sum_ready=1 at a rising edge completes the handshake:
    - with start=0 -> IDLE;
    - with start=1 -> ACCUM directly (back-to-back run; acc, cnt, overflow cleared as on IDLE start).
  - start without sum_ready is ignored.
- Boundary conditions:
  - N_SAMPLES=1: ACCUM lasts exactly one accepted sample.
  - in_data=0 is a legal sample and counts toward N_SAMPLES.
  - Counter wrap from 0 to 31 upstream has no special meaning here.
  - Worst case 31*31=961 exceeds 2^8-1, so overflow is reachable with default widths.

Optional Feature:
- Macro: SOMADOR_SATURATE_EN.
- Defined: on a carry-out, acc (and sum) clamp to 2^SUM_W-1 and stay there for the rest of the run; overflow is still set.
- Not defined: modulo-2^SUM_W wrap as described above; overflow is set.

Test Plan:
- Reset mid-run: after 2 of 4 samples accepted, pulse clear=0 -> same cycle: sum_valid=0, in_ready=0, busy=0, overflow=0, sum=0; a later start begins a fresh run.
- Basic sum: N_SAMPLES=4, start, then samples 31,30,29,28 with in_valid held high -> cycle after 4th accept: sum=118 (0x76), sum_valid=1, overflow=0, in_ready=0.
- Gapped input: same four samples with in_valid low on alternate cycles -> only handshaked samples counted; sum=118; sum_valid exactly one cycle after the 4th accept.
- Back-pressure: sum_ready held 0 for 5 cycles in HOLD -> sum_valid stays 1, sum stays 118, in_ready stays 0, in_valid pulses ignored; sum_ready=1 -> IDLE next cycle.
- Overflow: N_SAMPLES=16, all samples 31 (total 496):
  - without SOMADOR_SATURATE_EN -> sum=240, overflow=1;
  - with SOMADOR_SATURATE_EN -> sum=255, overflow=1.
- Back-to-back: start=1 together with sum_ready=1 in HOLD -> next cycle state ACCUM, in_ready=1, overflow=0; next four samples 1,2,3,4 -> sum=10.

Source files
------------

// File: rtl/somador_acumulador_5bits.sv
// Sample accumulator: sums N_SAMPLES zero-extended inputs over a valid/ready handshake
// and presents the result on a second handshake. Define SOMADOR_SATURATE_EN to clamp instead of wrap.
module somador_acumulador_5bits #(
  parameter int IN_W      = 5,
  parameter int SUM_W     = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // N_SAMPLES is limited to 1..31, so a 5-bit sample counter always suffices.
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [SUM_W:0]   raw_sum;
  logic             carry;
  logic [SUM_W-1:0] next_acc;

  assign raw_sum = {1'b0, acc} + {{(SUM_W + 1 - IN_W){1'b0}}, in_data};
  assign carry   = raw_sum[SUM_W];

`ifdef SOMADOR_SATURATE_EN
  // Once clamped, acc sits at all-ones: any non-zero sample carries again and
  // re-clamps, a zero sample leaves it unchanged, so no separate sticky bit is needed.
  assign next_acc = carry ? {SUM_W{1'b1}} : raw_sum[SUM_W-1:0];
`else
  assign next_acc = raw_sum[SUM_W-1:0];
`endif

  // Handshake outputs decode the registered state only, so no input reaches them combinationally.
  assign in_ready  = (state == ACCUM);
  assign sum_valid = (state == HOLD);
  assign busy      = (state == ACCUM) || (state == HOLD);

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values of acc/cnt, regardless of statement order.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      sum      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc      <= next_acc;
            cnt      <= cnt + 1'b1;
            overflow <= overflow | carry;
            if (cnt == LAST_IDX) begin
              sum   <= next_acc;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            if (start) begin
              state    <= ACCUM;
              acc      <= '0;
              cnt      <= '0;
              overflow <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_acumulador_5bits.sv
// Directed bench for somador_acumulador_5bits: a 4-sample instance for handshake/reset
// behaviour and a 16-sample instance for overflow (wrap or clamp under SOMADOR_SATURATE_EN).
module tb_somador_acumulador_5bits;

  logic       clk;
  logic       clear;

  logic       start, in_valid, sum_ready;
  logic [4:0] in_data;
  logic       in_ready, sum_valid, busy, overflow;
  logic [7:0] sum;

  logic       s_start, s_in_valid, s_sum_ready;
  logic [4:0] s_in_data;
  logic       s_in_ready, s_sum_valid, s_busy, s_overflow;
  logic [7:0] s_sum;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SOMADOR_SATURATE_EN
  localparam logic [7:0] OVF_SUM = 8'd255;
`else
  localparam logic [7:0] OVF_SUM = 8'd240;
`endif

  somador_acumulador_5bits #(.IN_W(5), .SUM_W(8), .N_SAMPLES(4)) dut (
    .clk(clk), .clear(clear), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .busy(busy), .overflow(overflow)
  );

  somador_acumulador_5bits #(.IN_W(5), .SUM_W(8), .N_SAMPLES(16)) dut16 (
    .clk(clk), .clear(clear), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .sum(s_sum), .sum_valid(s_sum_valid), .sum_ready(s_sum_ready),
    .busy(s_busy), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, inputs are driven there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b0;
    start = 0; in_valid = 0; sum_ready = 0; in_data = '0;
    s_start = 0; s_in_valid = 0; s_sum_ready = 0; s_in_data = '0;

    // Reset state
    #2;
    check("rst_sum_valid", 32'(sum_valid), 0);
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_busy",      32'(busy),      0);
    check("rst_overflow",  32'(overflow),  0);
    check("rst_sum",       32'(sum),       0);
    check("rst16_sum",     32'(s_sum),     0);
    #1 clear = 1'b1;
    step();

    // Basic sum: 31+30+29+28 = 118
    start = 1; step(); start = 0;
    check("basic_in_ready", 32'(in_ready), 1);
    check("basic_busy",     32'(busy),     1);
    in_valid = 1;
    in_data = 5'd31; step();
    in_data = 5'd30; step();
    in_data = 5'd29; step();
    check("basic_not_early", 32'(sum_valid), 0);
    in_data = 5'd28; step();
    in_valid = 0;
    check("basic_sum",       32'(sum),       118);
    check("basic_sum_valid", 32'(sum_valid), 1);
    check("basic_overflow",  32'(overflow),  0);
    check("basic_in_ready0", 32'(in_ready),  0);

    // Back-pressure: result held for 5 cycles while in_valid pulses
    in_data = 5'd5;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      step();
      check("bp_sum_valid", 32'(sum_valid), 1);
      check("bp_sum",       32'(sum),       118);
      check("bp_in_ready",  32'(in_ready),  0);
    end
    in_valid = 0;
    sum_ready = 1; step(); sum_ready = 0;
    check("bp_idle_sum_valid", 32'(sum_valid), 0);
    check("bp_idle_busy",      32'(busy),      0);
    check("bp_idle_sum_kept",  32'(sum),       118);

    // Gapped input: invalid cycles carry junk data that must not be counted
    start = 1; step(); start = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      case (i)
        0: in_data = 5'd31;
        2: in_data = 5'd30;
        4: in_data = 5'd29;
        6: in_data = 5'd28;
        default: in_data = 5'd7;
      endcase
      step();
      if (i < 6) check("gap_not_early", 32'(sum_valid), 0);
    end
    in_valid = 0;
    check("gap_sum_valid", 32'(sum_valid), 1);
    check("gap_sum",       32'(sum),       118);

    // Back-to-back: start with sum_ready in HOLD, then 1+2+3+4 = 10
    start = 1; sum_ready = 1; step(); start = 0; sum_ready = 0;
    check("b2b_in_ready",  32'(in_ready),  1);
    check("b2b_sum_valid", 32'(sum_valid), 0);
    check("b2b_overflow",  32'(overflow),  0);
    in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 5'(i);
      step();
    end
    in_valid = 0;
    check("b2b_sum_valid1", 32'(sum_valid), 1);
    check("b2b_sum",        32'(sum),       10);
    sum_ready = 1; step(); sum_ready = 0;
    check("b2b_idle", 32'(busy), 0);

    // Reset mid-run after 2 of 4 samples
    start = 1; step(); start = 0;
    in_valid = 1; in_data = 5'd9;
    step(); step();
    in_valid = 0;
    #2 clear = 1'b0;
    #1;
    check("mid_rst_sum_valid", 32'(sum_valid), 0);
    check("mid_rst_in_ready",  32'(in_ready),  0);
    check("mid_rst_busy",      32'(busy),      0);
    check("mid_rst_overflow",  32'(overflow),  0);
    check("mid_rst_sum",       32'(sum),       0);
    #1 clear = 1'b1;
    step();
    check("mid_rst_stays_idle", 32'(in_ready), 0);

    // Fresh run after reset; start held during ACCUM must not restart it
    start = 1; step();
    in_valid = 1; in_data = 5'd1;
    step(); step(); step();
    check("fresh_not_early", 32'(sum_valid), 0);
    step();
    in_valid = 0;
    check("fresh_sum_valid", 32'(sum_valid), 1);
    check("fresh_sum",       32'(sum),       4);
    // start without sum_ready in HOLD is ignored
    step();
    check("hold_start_ignored", 32'(sum_valid), 1);
    start = 0; sum_ready = 1; step(); sum_ready = 0;
    check("fresh_idle", 32'(busy), 0);

    // Overflow on the 16-sample instance: 16 * 31 = 496
    s_start = 1; step(); s_start = 0;
    s_in_valid = 1; s_in_data = 5'd31;
    for (int i = 0; i < 16; i++) step();
    s_in_valid = 0;
    check("ovf_sum_valid", 32'(s_sum_valid), 1);
    check("ovf_sum",       32'(s_sum),       32'(OVF_SUM));
    check("ovf_flag",      32'(s_overflow),  1);

    // Back-to-back clears the sticky overflow; 16 * 1 = 16
    s_start = 1; s_sum_ready = 1; step(); s_start = 0; s_sum_ready = 0;
    check("ovf_b2b_cleared",  32'(s_overflow), 0);
    check("ovf_b2b_in_ready", 32'(s_in_ready), 1);
    s_in_valid = 1; s_in_data = 5'd1;
    for (int i = 0; i < 16; i++) step();
    s_in_valid = 0;
    check("ovf_b2b_sum",      32'(s_sum),      16);
    check("ovf_b2b_overflow", 32'(s_overflow), 0);
    s_sum_ready = 1; step(); s_sum_ready = 0;
    check("ovf_b2b_idle", 32'(s_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
